flash_clkrst_retimer: RTL and testbench
=======================================

// Module: flash_clkrst_retimer
// PURPOSE
//  Parametrised, registered successor to the flash clock/reset lane buffer between the user project and the flash controller.
//  Carries N_S southbound and S_N northbound lanes through a STAGES-deep retiming pipeline per direction.
//  Adds a freeze/refill handshake for safe mode switches, plus per-lane reset-pulse stretching on lanes flagged by mask.
// PARAMETERS
//  N_S        12       southbound lane count (in_n -> out_s)
//  S_N        3        northbound lane count (in_s -> out_n)
//  STAGES     2        pipeline depth per direction, legal range 1..8
//  RST_MASK_S 12'h000  bit i=1: southbound lane i is an active-high reset lane and is stretched
//  RST_MASK_N 3'b000   bit i=1: northbound lane i is an active-high reset lane and is stretched
//  MIN_PULSE  4        minimum asserted cycles on a masked output after its pipelined input falls, 1..255
// PORTS
//  wb_clk_i   in   1    sole clock
//  wb_rst_i   in   1    synchronous, active-high reset
//  in_n       in   N_S  southbound lanes from north side
//  in_s       in   S_N  northbound lanes from south side
//  out_s      out  N_S  retimed southbound lanes
//  out_n      out  S_N  retimed northbound lanes
//  hold_req   in   1    level request to freeze both directions
//  hold_ack   out  1    1 = outputs frozen and stable
//  mon_sel    in   5    lane select for monitor: 0..N_S-1 south, N_S..N_S+S_N-1 north
//  mon_cnt    out  16   toggle count of selected output lane (optional feature)
// BEHAVIOUR
//  Reset (wb_rst_i=1 at a clock edge): all pipeline regs = 0; out_* unmasked bits = 0, masked bits = 1.
//   Stretch counters load MIN_PULSE, so masked outputs stay 1 for MIN_PULSE cycles after wb_rst_i falls.
//   FSM = RUN, hold_ack = 0, mon counters = 0.
//  Latency: in RUN, in_x sampled at edge t appears on out_x after edge t+STAGES-1; each lane is independent.
//  FSM states: RUN, FROZEN, REFILL.
//   RUN    -> FROZEN when hold_req=1. The pipeline, output regs and stretch counters stop at that edge; hold_ack=1 from the same edge.
//   FROZEN -> REFILL when hold_req=0. hold_ack stays 1 and outputs stay held.
//   REFILL: pipeline advances for STAGES cycles; outputs still held; stretch counters frozen.
//   REFILL -> RUN after STAGES cycles. Outputs resume and hold_ack=0 at the same edge.
//   hold_req=1 again during REFILL -> FROZEN immediately; refill count discarded and restarted on next release.
//  Stretch, per masked lane:
//   Pipelined bit = 1 -> cnt loads MIN_PULSE and out = 1.
//   Pipelined bit = 0 and cnt > 0 -> cnt-1 and out = 1.
//   cnt = 0 -> out = pipelined bit.
//   Re-assertion while counting reloads cnt (retriggerable). Unmasked lanes ignore stretch logic.
//  Counter widths: cnt is 8 bit; refill counter is $clog2(STAGES+1) bits.
//  Reset mid-freeze or mid-refill: full reset values apply; hold_req sampled fresh from RUN.
// CONFIGURATION
//  Macro FLASH_CLKRST_MON_EN.
//   Defined: 16-bit saturating (stops at 16'hFFFF) toggle counter per output lane.
//    Counts any out_* change between consecutive edges; counters hold while FROZEN/REFILL.
//    mon_cnt is a registered mux of counter[mon_sel], 1-cycle latency; mon_sel out of range returns 0.
//   Undefined: no counters built; mon_cnt tied to 16'h0000; mon_sel ignored.
// STRUCTURE
//  Package flash_clkrst_pkg:
//   FSM enum {RUN, FROZEN, REFILL}.
//   Default constants for N_S/S_N/STAGES/MIN_PULSE.
//   Localparam for monitor width (16).
//  Sub-module clkrst_lane_stretch: one masked lane: 8-bit counter, freeze input, reset load to MIN_PULSE.
//   Instantiated via generate only where the mask bit is 1.
//  Top holds FSM, both pipelines, refill counter, optional monitor.
// TESTING
//  Reset release, STAGES=2, MIN_PULSE=4, RST_MASK_S[0]=1, inputs 0 ->
//   out_s[0]=1 for exactly 4 cycles after wb_rst_i falls; all other outputs 0.
//  Pulse: in_n=12'hA5A at edge t, RUN -> out_s=12'hA5A after edge t+1; out_n unaffected.
//  Freeze: hold_req=1 while out_s=12'h0F0 -> hold_ack=1 at that edge; out_s stays 12'h0F0 under input changes.
//   Release -> hold_ack falls exactly STAGES=2 cycles after FROZEN exit; out_s = input of 2 cycles prior.
//  Retrigger: masked lane input 1-cycle pulses 3 cycles apart, MIN_PULSE=4 -> output continuously 1 until 4 cycles after last pulse.
//  Re-freeze during REFILL: hold_req 1->0->1 within STAGES cycles -> hold_ack never drops; outputs never change.
//  FLASH_CLKRST_MON_EN: toggle out_n[1] 10 times, mon_sel=N_S+1 -> mon_cnt=10; 70000 toggles -> 16'hFFFF.

Source files
------------

// File: rtl/flash_clkrst_pkg.sv
// Shared types and defaults for the flash clock/reset retimer.
// FSM encoding, default geometry and the monitor counter width.
package flash_clkrst_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FROZEN = 2'd1,
        REFILL = 2'd2
    } fsm_state_t;

    localparam int DEF_N_S       = 12;
    localparam int DEF_S_N       = 3;
    localparam int DEF_STAGES    = 2;
    localparam int DEF_MIN_PULSE = 4;
    localparam int MON_W         = 16;

endpackage

// File: rtl/flash_clkrst_retimer_stretch.sv
// Output register for one active-high reset lane: holds the lane high for
// MIN_PULSE extra advances after its pipelined bit falls (retriggerable).
module clkrst_lane_stretch
    import flash_clkrst_pkg::*;
#(
    parameter int MIN_PULSE = DEF_MIN_PULSE
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic pipe_bit,
    output logic out_bit
);

    localparam logic [7:0] LOAD = 8'(MIN_PULSE);

    logic [7:0] cnt_reg;
    logic       out_reg;

    // Reset behaves like a pipelined 1, so the lane is stretched out of reset too.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= LOAD;
            out_reg <= 1'b1;
        end else if (en) begin
            if (pipe_bit) begin
                cnt_reg <= LOAD;
                out_reg <= 1'b1;
            end else if (cnt_reg != 8'd0) begin
                cnt_reg <= cnt_reg - 8'd1;
                out_reg <= 1'b1;
            end else begin
                out_reg <= 1'b0;
            end
        end
    end

    assign out_bit = out_reg;

endmodule

// File: rtl/flash_clkrst_retimer.sv
// Registered clock/reset lane buffer with freeze/refill handshake and reset stretching.
// Optional per-lane toggle monitor enabled by defining FLASH_CLKRST_MON_EN.
module flash_clkrst_retimer
    import flash_clkrst_pkg::*;
#(
    parameter int             N_S        = DEF_N_S,
    parameter int             S_N        = DEF_S_N,
    parameter int             STAGES     = DEF_STAGES,
    parameter logic [N_S-1:0] RST_MASK_S = '0,
    parameter logic [S_N-1:0] RST_MASK_N = '0,
    parameter int             MIN_PULSE  = DEF_MIN_PULSE
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [N_S-1:0]   in_n,
    input  logic [S_N-1:0]   in_s,
    output logic [N_S-1:0]   out_s,
    output logic [S_N-1:0]   out_n,
    input  logic             hold_req,
    output logic             hold_ack,
    input  logic [4:0]       mon_sel,
    output logic [MON_W-1:0] mon_cnt
);

    localparam int LANES = N_S + S_N;
    localparam int RW    = $clog2(STAGES + 1);
    localparam logic [RW-1:0]    REFILL_LAST = RW'(STAGES - 1);
    localparam logic [LANES-1:0] LANE_MASK   = {RST_MASK_N, RST_MASK_S};

    fsm_state_t       state_reg;
    logic [RW-1:0]    refill_cnt_reg;
    logic             hold_ack_reg;
    logic             pipe_en;
    logic             out_en;
    logic [LANES-1:0] lane_in;
    logic [LANES-1:0] pipe_bits;
    logic [LANES-1:0] out_lanes;

    // Both directions share one lane vector: south lanes low, north lanes high.
    assign lane_in = {in_s, in_n};

    // The last refill edge also reloads the outputs, so resume costs no extra cycle.
    always_comb begin
        pipe_en = !hold_req && (state_reg == RUN || state_reg == REFILL);
        out_en  = !hold_req && (state_reg == RUN ||
                  (state_reg == REFILL && refill_cnt_reg == REFILL_LAST));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= RUN;
            refill_cnt_reg <= '0;
            hold_ack_reg   <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (hold_req) begin
                        state_reg    <= FROZEN;
                        hold_ack_reg <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (!hold_req) begin
                        state_reg      <= REFILL;
                        refill_cnt_reg <= '0;
                    end
                end
                REFILL: begin
                    if (hold_req) begin
                        state_reg <= FROZEN;
                    end else if (refill_cnt_reg == REFILL_LAST) begin
                        state_reg    <= RUN;
                        hold_ack_reg <= 1'b0;
                    end else begin
                        refill_cnt_reg <= refill_cnt_reg + RW'(1);
                    end
                end
                default: begin
                    state_reg    <= RUN;
                    hold_ack_reg <= 1'b0;
                end
            endcase
        end
    end

    assign hold_ack = hold_ack_reg;

    // STAGES-1 plain stages; the lane output register forms the final stage.
    generate
        if (STAGES == 1) begin : g_nopipe
            assign pipe_bits = lane_in;
        end else begin : g_pipe
            logic [LANES-1:0] pipe_reg [STAGES-1];
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int i = 0; i < STAGES - 1; i++) pipe_reg[i] <= '0;
                end else if (pipe_en) begin
                    pipe_reg[0] <= lane_in;
                    for (int i = 1; i < STAGES - 1; i++) pipe_reg[i] <= pipe_reg[i-1];
                end
            end
            assign pipe_bits = pipe_reg[STAGES-2];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (LANE_MASK[gi]) begin : g_str
                clkrst_lane_stretch #(.MIN_PULSE(MIN_PULSE)) u_stretch (
                    .clk      (wb_clk_i),
                    .srst     (wb_rst_i),
                    .en       (out_en),
                    .pipe_bit (pipe_bits[gi]),
                    .out_bit  (out_lanes[gi])
                );
            end else begin : g_plain
                logic out_reg;
                always_ff @(posedge wb_clk_i) begin
                    if (wb_rst_i)    out_reg <= 1'b0;
                    else if (out_en) out_reg <= pipe_bits[gi];
                end
                assign out_lanes[gi] = out_reg;
            end
        end
    endgenerate

    assign out_s = out_lanes[N_S-1:0];
    assign out_n = out_lanes[LANES-1:N_S];

`ifdef FLASH_CLKRST_MON_EN
    logic [MON_W-1:0] tog_cnt [LANES];
    logic [LANES-1:0] out_prev_reg;
    logic [MON_W-1:0] mon_mux;
    logic [MON_W-1:0] mon_cnt_reg;

    // Outputs never move while frozen, so the counters hold without extra gating.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) out_prev_reg <= LANE_MASK;
        else          out_prev_reg <= out_lanes;
    end

    for (gi = 0; gi < LANES; gi++) begin : g_mon
        logic [MON_W-1:0] cnt_reg;
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i)
                cnt_reg <= '0;
            else if (out_lanes[gi] != out_prev_reg[gi] && cnt_reg != '1)
                cnt_reg <= cnt_reg + MON_W'(1);
        end
        assign tog_cnt[gi] = cnt_reg;
    end

    always_comb begin
        mon_mux = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(mon_sel) == i) mon_mux = tog_cnt[i];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) mon_cnt_reg <= '0;
        else          mon_cnt_reg <= mon_mux;
    end

    assign mon_cnt = mon_cnt_reg;
`else
    logic mon_sel_unused;
    assign mon_sel_unused = ^mon_sel;
    assign mon_cnt = '0;
`endif

endmodule

// File: tb/tb_flash_clkrst_retimer.sv
// Self-checking bench for flash_clkrst_retimer with a behavioural lane model.
module tb_flash_clkrst_retimer;

    localparam int N_S = 12;
    localparam int S_N = 3;
    localparam int LANES = 15;
    localparam int STAGES = 2;
    localparam int MIN_PULSE = 4;
    localparam logic [N_S-1:0] RMS = 12'h001;
    localparam logic [S_N-1:0] RMN = 3'b100;
    localparam logic [LANES-1:0] MASK = {RMN, RMS};

    logic clk = 1'b0;
    logic wb_rst_i = 1'b1;
    logic [N_S-1:0] in_n = '0;
    logic [S_N-1:0] in_s = '0;
    logic [N_S-1:0] out_s;
    logic [S_N-1:0] out_n;
    logic hold_req = 1'b0;
    logic hold_ack;
    logic [4:0] mon_sel = '0;
    logic [15:0] mon_cnt;

    int total = 0;
    int bad = 0;

    // model state
    logic [LANES-1:0] pq[$];
    logic [LANES-1:0] hist[$];
    logic [LANES-1:0] m_out;
    bit m_frozen;
    int m_refill;
    bit m_ack;
    int m_tog[LANES];

    flash_clkrst_retimer #(
        .N_S(N_S), .S_N(S_N), .STAGES(STAGES),
        .RST_MASK_S(RMS), .RST_MASK_N(RMN), .MIN_PULSE(MIN_PULSE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .in_n(in_n), .in_s(in_s), .out_s(out_s), .out_n(out_n),
        .hold_req(hold_req), .hold_ack(hold_ack),
        .mon_sel(mon_sel), .mon_cnt(mon_cnt)
    );

    initial forever #5 clk = ~clk;

    // Model: the output of a masked lane is high if any of the last
    // MIN_PULSE+1 pipelined bits it accepted was high (reset counts as high).
    task automatic model_edge(input logic r, input logic h, input logic [LANES-1:0] w);
        logic [LANES-1:0] pb, nout, acc;
        bit do_pipe, do_out;
        pb = '0;
        nout = m_out;
        if (r) begin
            pq.delete();
            for (int i = 0; i < STAGES - 1; i++) pq.push_back('0);
            hist.delete();
            hist.push_back(MASK);
            m_out = MASK;
            m_frozen = 0;
            m_refill = 0;
            m_ack = 0;
            for (int i = 0; i < LANES; i++) m_tog[i] = 0;
            return;
        end
        do_pipe = 0;
        do_out = 0;
        if (m_frozen) begin
            if (!h) begin m_frozen = 0; m_refill = STAGES; end
        end else if (m_refill > 0) begin
            if (h) begin
                m_frozen = 1;
                m_refill = 0;
            end else begin
                do_pipe = 1;
                m_refill--;
                if (m_refill == 0) begin do_out = 1; m_ack = 0; end
            end
        end else begin
            if (h) begin m_frozen = 1; m_ack = 1; end
            else begin do_pipe = 1; do_out = 1; end
        end
        if (do_pipe) begin
            pq.push_back(w);
            pb = pq.pop_front();
        end
        if (do_out) begin
            hist.push_back(pb);
            if (hist.size() > MIN_PULSE + 1) void'(hist.pop_front());
            acc = '0;
            foreach (hist[i]) acc |= hist[i];
            nout = (pb & ~MASK) | (acc & MASK);
        end
        for (int i = 0; i < LANES; i++)
            if (nout[i] != m_out[i] && m_tog[i] < 65535) m_tog[i]++;
        m_out = nout;
    endtask

    task automatic step(input logic r, input logic h, input logic [N_S-1:0] n, input logic [S_N-1:0] s);
        wb_rst_i = r;
        hold_req = h;
        in_n = n;
        in_s = s;
        @(posedge clk);
        model_edge(r, h, {s, n});
        #1;
    endtask

    task automatic test_reset();
        logic exp0;
        step(1, 0, '0, '0);
        step(1, 1, '0, '0);
        total++;
        if (out_s !== 12'h001 || out_n !== 3'b100) begin
            bad++;
            $display("FAIL reset_out: out_s=%h out_n=%b required out_s=001 out_n=100", out_s, out_n);
        end
        total++;
        if (hold_ack !== 1'b0 || mon_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_ack: hold_ack=%b mon_cnt=%h required 0/0000", hold_ack, mon_cnt);
        end
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, '0, '0);
            exp0 = (k <= MIN_PULSE);
            total++;
            if (out_s !== {11'b0, exp0} || out_n !== {exp0, 2'b0}) begin
                bad++;
                $display("FAIL reset_stretch k=%0d: out_s=%h out_n=%b required out_s=%h out_n=%b",
                         k, out_s, out_n, {11'b0, exp0}, {exp0, 2'b0});
            end
        end
    endtask

    task automatic test_pulse();
        for (int k = 0; k < 6; k++) step(0, 0, '0, '0);
        step(0, 0, 12'hA5A, '0);
        total++;
        if (out_s !== 12'h000) begin
            bad++;
            $display("FAIL pulse_early: out_s=%h required 000", out_s);
        end
        step(0, 0, '0, '0);
        total++;
        if (out_s !== 12'hA5A || out_n !== 3'b000) begin
            bad++;
            $display("FAIL pulse_arrive: out_s=%h out_n=%b required A5A/000", out_s, out_n);
        end
        step(0, 0, '0, '0);
        total++;
        if (out_s !== 12'h000) begin
            bad++;
            $display("FAIL pulse_clear: out_s=%h required 000", out_s);
        end
    endtask

    task automatic test_freeze();
        logic [N_S-1:0] v[$];
        logic [N_S-1:0] r;
        int cnt;
        for (int k = 0; k < 6; k++) step(0, 0, '0, '0);
        for (int k = 0; k < 3; k++) step(0, 0, 12'h0F0, '0);
        step(0, 1, 12'($urandom) & 12'hFFE, '0);
        total++;
        if (hold_ack !== 1'b1 || out_s !== 12'h0F0) begin
            bad++;
            $display("FAIL freeze_enter: hold_ack=%b out_s=%h required 1/0F0", hold_ack, out_s);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 12'($urandom) & 12'hFFE, 3'($urandom));
            total++;
            if (out_s !== 12'h0F0) begin
                bad++;
                $display("FAIL freeze_hold: out_s=%h required 0F0", out_s);
            end
        end
        step(0, 0, 12'($urandom) & 12'hFFE, '0);
        cnt = 0;
        v.push_back('0);
        while (hold_ack === 1'b1 && cnt < 8) begin
            r = 12'($urandom) & 12'hFFE;
            v.push_back(r);
            step(0, 0, r, '0);
            cnt++;
            if (hold_ack === 1'b1) begin
                total++;
                if (out_s !== 12'h0F0) begin
                    bad++;
                    $display("FAIL refill_hold: out_s=%h required 0F0", out_s);
                end
            end
        end
        total++;
        if (cnt !== STAGES) begin
            bad++;
            $display("FAIL refill_len: cycles=%0d required %0d", cnt, STAGES);
        end
        total++;
        if (cnt >= 2 && out_s !== v[cnt-1]) begin
            bad++;
            $display("FAIL refill_data: out_s=%h required %h", out_s, v[cnt-1]);
        end
    endtask

    task automatic test_retrigger();
        logic exp0;
        int k;
        for (int i = 0; i < 6; i++) step(0, 0, '0, '0);
        k = 0;
        for (int p = 0; p < 18; p++) begin
            step(0, 0, (p % 3 == 0 && p <= 9) ? 12'h001 : 12'h000, '0);
            exp0 = (k >= 1 && k <= 9 + 1 + MIN_PULSE);
            total++;
            if (out_s[0] !== exp0 || out_s !== m_out[N_S-1:0]) begin
                bad++;
                $display("FAIL retrigger k=%0d: out_s=%h required lane0=%b model=%h", k, out_s, exp0, m_out[N_S-1:0]);
            end
            k++;
        end
    endtask

    task automatic test_refreeze();
        logic h_seq[8];
        h_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) step(0, 0, 12'h3C0, '0);
        for (int k = 0; k < 8; k++) begin
            step(0, h_seq[k], 12'($urandom) & 12'hFFE, '0);
            if (k < 7) begin
                total++;
                if (hold_ack !== 1'b1 || out_s !== 12'h3C0) begin
                    bad++;
                    $display("FAIL refreeze k=%0d: hold_ack=%b out_s=%h required 1/3C0", k, hold_ack, out_s);
                end
            end
        end
        total++;
        if (hold_ack !== 1'b0 || out_s !== m_out[N_S-1:0]) begin
            bad++;
            $display("FAIL refreeze_resume: hold_ack=%b out_s=%h required 0/%h", hold_ack, out_s, m_out[N_S-1:0]);
        end
    endtask

    task automatic test_random();
        logic h;
        logic r;
        h = 0;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) h = ~h;
            step(r, h, 12'($urandom), 3'($urandom));
            total++;
            if ({hold_ack, out_n, out_s} !== {m_ack, m_out}) begin
                bad++;
                $display("FAIL random k=%0d: ack/out=%b/%h required %b/%h", k, hold_ack, {out_n, out_s}, m_ack, m_out);
            end
        end
    endtask

    task automatic test_monitor();
`ifdef FLASH_CLKRST_MON_EN
        logic [S_N-1:0] s;
        step(1, 0, '0, '0);
        mon_sel = 5'(N_S + 1);
        s = '0;
        for (int k = 0; k < 10; k++) begin
            s[1] = ~s[1];
            step(0, 0, '0, s);
        end
        for (int k = 0; k < 4; k++) step(0, 0, '0, s);
        total++;
        if (mon_cnt !== 16'd10 || int'(mon_cnt) != m_tog[N_S+1]) begin
            bad++;
            $display("FAIL mon_10: mon_cnt=%0d required 10 (model %0d)", mon_cnt, m_tog[N_S+1]);
        end
        for (int k = 0; k < 70000; k++) begin
            s[1] = ~s[1];
            step(0, 0, '0, s);
        end
        for (int k = 0; k < 4; k++) step(0, 0, '0, s);
        total++;
        if (mon_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL mon_sat: mon_cnt=%h required FFFF", mon_cnt);
        end
        mon_sel = 5'd31;
        step(0, 0, '0, s);
        step(0, 0, '0, s);
        total++;
        if (mon_cnt !== 16'h0) begin
            bad++;
            $display("FAIL mon_range: mon_cnt=%h required 0000", mon_cnt);
        end
`else
        for (int k = 0; k < 4; k++) begin
            mon_sel = 5'($urandom);
            step(0, 0, 12'($urandom), 3'($urandom));
            total++;
            if (mon_cnt !== 16'h0) begin
                bad++;
                $display("FAIL mon_off: mon_cnt=%h required 0000", mon_cnt);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_freeze();
        test_retrigger();
        test_refreeze();
        test_random();
        test_monitor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
